// File: rtl/fp8_mul_scheduler.sv
// Round-robin scheduler sharing one pipelined FP8 vector multiplier
// between several requesters, with mode-change draining and tagged responses.
module fp8_mul_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int MUL_LATENCY = 3,
  parameter int MAX_BURST = 16,
  localparam int IDX_W = $clog2(NUM_REQ),
  localparam int ID_WIDTH = IDX_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_mode,
  input  logic [8*NUM_REQ-1:0]    req_q,
  input  logic [32*NUM_REQ-1:0]   req_vec,
  output logic                    rsp_valid,
  output logic [IDX_W-1:0]        rsp_dest,
  output logic [63:0]             rsp_data,
  output logic [7:0]              mul_q,
  output logic [31:0]             mul_vec,
  output logic                    mul_e5m2mode,
  output logic [ID_WIDTH-1:0]     mul_id,
  input  logic [63:0]             mul_res,
  input  logic [ID_WIDTH-1:0]     mul_id_out,
  output logic                    busy,
  output logic                    tag_err
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_n;

  logic             cur_mode;
  logic [IDX_W-1:0] rr_ptr;
  logic [BW-1:0]    burst_cnt;

  logic [MUL_LATENCY-1:0] trk_v;
  logic [IDX_W-1:0]       trk_idx [MUL_LATENCY];

  logic             elig_found;
  logic [IDX_W-1:0] elig_idx;
  logic             vld_found;
  logic [IDX_W-1:0] vld_idx;
  logic             other_pend;
  logic             burst_full;
  logic             need_switch;
  logic             pipe_empty;
  logic             issue;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0] rr_next;
  int               j;

  // Scan from rr_ptr: first same-mode requester and first valid one
  always_comb begin
    j = 0;
    elig_found = 1'b0;
    elig_idx = '0;
    vld_found = 1'b0;
    vld_idx = '0;
    other_pend = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!elig_found && req_valid[j] &&
          (req_mode[j] == cur_mode)) begin
        elig_found = 1'b1;
        elig_idx = IDX_W'(j);
      end
      if (!vld_found && req_valid[j]) begin
        vld_found = 1'b1;
        vld_idx = IDX_W'(j);
      end
      if (req_valid[j] && (req_mode[j] != cur_mode))
        other_pend = 1'b1;
    end
  end

  assign burst_full = (burst_cnt == BW'(MAX_BURST));
  assign need_switch = other_pend &
                       (!elig_found || burst_full);
  assign pipe_empty = !mul_id[ID_WIDTH-1] && !(|trk_v);
  assign rr_next = (elig_idx == IDX_W'(NUM_REQ - 1)) ?
                   '0 : elig_idx + 1'b1;

  always_comb begin
    state_n = state;
    issue = 1'b0;
    grant = '0;
    unique case (state)
      IDLE: begin
        if (|req_valid)
          state_n = RUN;
      end
      RUN: begin
        if (need_switch) begin
          state_n = DRAIN;
        end else if (elig_found) begin
          issue = 1'b1;
          grant[elig_idx] = 1'b1;
        end else if (!(|req_valid) && pipe_empty) begin
          state_n = IDLE;
        end
      end
      DRAIN: begin
        if (pipe_empty)
          state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  assign req_ready = grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cur_mode <= 1'b0;
      rr_ptr <= '0;
      burst_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n == RUN) begin
        cur_mode <= req_mode[vld_idx];
        burst_cnt <= '0;
      end else if (state == DRAIN && state_n == RUN) begin
        cur_mode <= ~cur_mode;
        burst_cnt <= '0;
      end else if (issue && !burst_full) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
      if (issue)
        rr_ptr <= rr_next;
    end
  end

  // Operands hold their last value when idle; only the tag is cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_q <= '0;
      mul_vec <= '0;
      mul_id <= '0;
    end else if (issue) begin
      mul_q <= req_q[int'(elig_idx)*8 +: 8];
      mul_vec <= req_vec[int'(elig_idx)*32 +: 32];
      mul_id <= {1'b1, elig_idx};
    end else begin
      mul_id <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk_v <= '0;
      for (int k = 0; k < MUL_LATENCY; k++)
        trk_idx[k] <= '0;
    end else begin
      trk_v[0] <= mul_id[ID_WIDTH-1];
      trk_idx[0] <= mul_id[IDX_W-1:0];
      for (int k = 1; k < MUL_LATENCY; k++) begin
        trk_v[k] <= trk_v[k-1];
        trk_idx[k] <= trk_idx[k-1];
      end
    end
  end

  assign rsp_valid = trk_v[MUL_LATENCY-1];
  assign rsp_dest = trk_idx[MUL_LATENCY-1];
  assign rsp_data = rsp_valid ? mul_res : '0;
  assign mul_e5m2mode = cur_mode;
  assign busy = (state != IDLE) || !pipe_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_err <= 1'b0;
    end else if (rsp_valid &&
                 (mul_id_out != {1'b1, rsp_dest})) begin
      tag_err <= 1'b1;
    end else if (!rsp_valid && mul_id_out[ID_WIDTH-1]) begin
      tag_err <= 1'b1;
    end
  end

endmodule
